// File: rtl/wb_ram_1p_ctrl_if.sv
// Wishbone B3 bus bundle between a master and wb_ram_1p_ctrl.
// Signals (names from the Wishbone slave's point of view):
//   wb_cyc_i, wb_stb_i   bus cycle valid / strobe
//   wb_we_i              1 = write
//   wb_sel_i             byte lane selects (DATA_WIDTH/8 bits)
//   wb_adr_i             byte address, [1:0] ignored by the slave
//   wb_dat_i             write data
//   wb_cti_i, wb_bte_i   cycle type / burst type
//   wb_dat_o, wb_ack_o   read data / acknowledge
interface wb_ram_1p_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    wb_cyc_i;
    logic                    wb_stb_i;
    logic                    wb_we_i;
    logic [DATA_WIDTH/8-1:0] wb_sel_i;
    logic [31:0]             wb_adr_i;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic [2:0]              wb_cti_i;
    logic [1:0]              wb_bte_i;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic                    wb_ack_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i,
               wb_dat_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i,
               wb_dat_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_ram_1p_ctrl.sv
// Wishbone B3 slave front end for a single-port synchronous RAM whose
// address is registered (q is valid the cycle after the address).
// Byte-lane writes are done as read-modify-write since the RAM has no
// byte enables. Linear incrementing read bursts run at one beat per clock.
// Ports:
//   clk       single clock, posedge
//   reset_n   asynchronous active-low reset
//   wb        Wishbone slave modport (see wb_ram_1p_ctrl_if)
//   ram_addr  RAM word address
//   ram_data  RAM write data
//   ram_we    RAM write enable
//   ram_q     RAM read data
module wb_ram_1p_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    wb_ram_1p_ctrl_if.slave       wb,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, RD, RMW, WR} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdat_r;
    logic                  ack_r;

    logic                  req;
    logic                  full_sel;
    logic                  cont;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic                  unused_ok;

    // Keep selected lanes of the new data, fill the rest from the old word.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [SEL_WIDTH-1:0]  sel
    );
        logic [DATA_WIDTH-1:0] res;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            res[8*i +: 8] = sel[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

    assign req      = wb.wb_cyc_i & wb.wb_stb_i;
    assign full_sel = &wb.wb_sel_i;
    // Only linear incrementing bursts continue; anything else ends after this beat.
    assign cont     = req & (wb.wb_cti_i == 3'b010) & (wb.wb_bte_i == 2'b00);
    assign bus_addr = wb.wb_adr_i[ADDR_WIDTH+1:2];
    // Natural overflow gives the modulo-2**ADDR_WIDTH burst wrap.
    assign addr_inc = addr_r + ADDR_WIDTH'(1);
    assign unused_ok = &{1'b0, wb.wb_adr_i[1:0], wb.wb_adr_i[31:ADDR_WIDTH+2]};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (!wb.wb_we_i)   state_nxt = RD;
                    else if (full_sel) state_nxt = WR;
                    else               state_nxt = RMW;
                end
            end
            RD:      state_nxt = cont ? RD : IDLE;
            RMW:     state_nxt = WR;   // completes even if the master has left
            WR:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        ram_addr = addr_r;
        ram_we   = 1'b0;
        case (state)
            IDLE:    ram_addr = bus_addr;
            // Present the next word now so it is on ram_q for the next beat.
            RD:      ram_addr = cont ? addr_inc : addr_r;
            WR:      ram_we   = 1'b1;
            default: ram_addr = addr_r;
        endcase
    end

    assign ram_data    = wdat_r;
    assign wb.wb_dat_o = ram_q;
    // Gated so a master dropping cyc/stb never sees a stale ack.
    assign wb.wb_ack_o = ack_r & req;

    // Address, write data and ack registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_r <= '0;
            wdat_r <= '0;
            ack_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_r <= bus_addr;
                        wdat_r <= wb.wb_dat_i;
                        ack_r  <= ~wb.wb_we_i | full_sel;
                    end else begin
                        ack_r  <= 1'b0;
                    end
                end
                RD: begin
                    if (cont) begin
                        addr_r <= addr_inc;
                        ack_r  <= 1'b1;
                    end else begin
                        ack_r  <= 1'b0;
                    end
                end
                RMW: begin
                    wdat_r <= merge_lanes(wdat_r, ram_q, wb.wb_sel_i);
                    ack_r  <= 1'b1;
                end
                default: ack_r <= 1'b0;
            endcase
        end
    end
endmodule
